// File: rtl/gf180mcu_dbnc_pkg.sv
// Shared types and default constants for the synchronised debounce cells.
package gf180mcu_dbnc_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    RISE_PEND   = 2'd1,
    HIGH_STABLE = 2'd2,
    FALL_PEND   = 2'd3
  } dbnc_state_e;

  localparam int unsigned DBNC_SYNC_STAGES = 2;
  localparam int unsigned DBNC_FILT_LEN    = 4;
  localparam int unsigned DBNC_CNT_W       = 8;

endpackage

// File: rtl/gf180mcu_sync_rn.sv
// N-stage level synchroniser with asynchronous active-low clear.
module gf180mcu_sync_rn #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  if (N < 2) begin : g_bad_depth
    $error("gf180mcu_sync_rn: N must be at least 2");
  end

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/gf180mcu_and3_dbnc.sv
// Synchronised, debounced A1&A2&A3 with registered level and edge pulses.
// Optional sticky rise flag with CLR when GF180MCU_AND3_DBNC_STICKY_EN is defined.
module gf180mcu_and3_dbnc
  import gf180mcu_dbnc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DBNC_SYNC_STAGES,
  parameter int unsigned FILT_LEN    = DBNC_FILT_LEN,
  parameter int unsigned CNT_W       = DBNC_CNT_W
) (
  input  logic CLK,
  input  logic RN,
  input  logic A1,
  input  logic A2,
  input  logic A3,
`ifdef GF180MCU_AND3_DBNC_STICKY_EN
  input  logic CLR,
  output logic ZSTICKY,
`endif
  output logic Z,
  output logic ZRISE,
  output logic ZFALL
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("gf180mcu_and3_dbnc: SYNC_STAGES must be 2..4");
  end
  if (FILT_LEN < 1 || FILT_LEN > 255) begin : g_bad_filt
    $error("gf180mcu_and3_dbnc: FILT_LEN must be 1..255");
  end
  if (CNT_W < 1 || CNT_W > 32 || (64'd1 << CNT_W) <= 64'(FILT_LEN)) begin : g_bad_cnt
    $error("gf180mcu_and3_dbnc: 2**CNT_W must exceed FILT_LEN");
  end

  localparam logic [CNT_W-1:0] FILT_C  = CNT_W'(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic        z_raw_c;
  logic        zs;
  dbnc_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic        z_q, z_d;
  logic        rise_q, rise_d;
  logic        fall_q, fall_d;

  assign z_raw_c = A1 & A2 & A3;

  gf180mcu_sync_rn #(
    .N(SYNC_STAGES)
  ) u_sync (
    .clk  (CLK),
    .rst_n(RN),
    .d    (z_raw_c),
    .q    (zs)
  );

  // The sample that leaves a stable state counts as the first of the run,
  // so FILT_LEN=1 accepts on that very sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    case (state_q)
      LOW_STABLE: begin
        z_d   = 1'b0;
        cnt_d = '0;
        if (zs) begin
          if (CNT_ONE == FILT_C) begin
            state_d = HIGH_STABLE;
            z_d     = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = RISE_PEND;
            cnt_d   = CNT_ONE;
          end
        end
      end
      RISE_PEND: begin
        z_d = 1'b0;
        if (!zs) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else if (cnt_inc == FILT_C) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
          z_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HIGH_STABLE: begin
        z_d   = 1'b1;
        cnt_d = '0;
        if (!zs) begin
          if (CNT_ONE == FILT_C) begin
            state_d = LOW_STABLE;
            z_d     = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = FALL_PEND;
            cnt_d   = CNT_ONE;
          end
        end
      end
      FALL_PEND: begin
        z_d = 1'b1;
        if (zs) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else if (cnt_inc == FILT_C) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
          z_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
        z_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign Z     = z_q;
  assign ZRISE = rise_q;
  assign ZFALL = fall_q;

`ifdef GF180MCU_AND3_DBNC_STICKY_EN
  logic sticky_q, sticky_d;

  // Set has priority over a coincident clear.
  always_comb begin
    sticky_d = rise_d | (sticky_q & ~CLR);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ZSTICKY = sticky_q;
`endif

endmodule

// File: tb/tb_gf180mcu_and3_dbnc.sv
// Bench for gf180mcu_and3_dbnc: default instance (2/4) and a fast instance (3/1)
// checked against a run-length reference model; sticky checks with GF180MCU_AND3_DBNC_STICKY_EN.
module tb_gf180mcu_and3_dbnc;

  logic clk;
  logic rn;
  logic a1, a2, a3;
  logic clr;
  wire [1:0] z, zr, zf;
  wire [1:0] mz_w, mr_w, mf_w, ms_w;
`ifdef GF180MCU_AND3_DBNC_STICKY_EN
  wire [1:0] zst;
`endif

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned SS = (g == 0) ? 2 : 3;
    localparam int unsigned FL = (g == 0) ? 4 : 1;

    gf180mcu_and3_dbnc #(
      .SYNC_STAGES(SS),
      .FILT_LEN   (FL),
      .CNT_W      (8)
    ) u_dut (
      .CLK    (clk),
      .RN     (rn),
      .A1     (a1),
      .A2     (a2),
      .A3     (a3),
`ifdef GF180MCU_AND3_DBNC_STICKY_EN
      .CLR    (clr),
      .ZSTICKY(zst[g]),
`endif
      .Z      (z[g]),
      .ZRISE  (zr[g]),
      .ZFALL  (zf[g])
    );

    // Reference: the AND seen SS clocks late; Z flips once FL consecutive
    // samples disagree with it.
    logic [3:0] hist;
    logic       smp;
    int         run;
    logic       mz, mr, mf, ms;

    always @(posedge clk or negedge rn) begin
      if (!rn) begin
        hist = '0;
        run  = 0;
        mz   = 1'b0;
        mr   = 1'b0;
        mf   = 1'b0;
        ms   = 1'b0;
      end else begin
        smp = hist[SS-1];
        mr  = 1'b0;
        mf  = 1'b0;
        if (smp != mz) begin
          run = run + 1;
          if (run >= int'(FL)) begin
            mz  = smp;
            mr  = smp;
            mf  = ~smp;
            run = 0;
          end
        end else begin
          run = 0;
        end
        ms   = mr | (ms & ~clr);
        hist = {hist[2:0], a1 & a2 & a3};
      end
    end

    assign mz_w[g] = mz;
    assign mr_w[g] = mr;
    assign mf_w[g] = mf;
    assign ms_w[g] = ms;
  end

  task automatic test_reset;
    rn = 1'b0;
    {a1, a2, a3} = 3'b111;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({z, zr, zf} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got z=%b zr=%b zf=%b expected all 0", z, zr, zf);
    end
    rn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      total++;
      if (z[0] !== 1'(k >= 6) || zr[0] !== 1'(k == 6) || zf[0] !== 1'b0) begin
        bad++;
        $display("FAIL reset_rise_dut0 k=%0d: got z=%b zr=%b zf=%b expected z=%b zr=%b zf=0",
                 k, z[0], zr[0], zf[0], 1'(k >= 6), 1'(k == 6));
      end
      total++;
      if (z[1] !== 1'(k >= 4) || zr[1] !== 1'(k == 4)) begin
        bad++;
        $display("FAIL reset_rise_dut1 k=%0d: got z=%b zr=%b expected z=%b zr=%b",
                 k, z[1], zr[1], 1'(k >= 4), 1'(k == 4));
      end
    end
  endtask

  task automatic test_glitch;
    a3 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      total++;
      if (z[0] !== 1'b1 || zf[0] !== 1'b0) begin
        bad++;
        $display("FAIL glitch_hold k=%0d: got z=%b zf=%b expected z=1 zf=0", k, z[0], zf[0]);
      end
      for (int g = 0; g < 2; g++) begin
        total++;
        if ({z[g], zr[g], zf[g]} !== {mz_w[g], mr_w[g], mf_w[g]}) begin
          bad++;
          $display("FAIL glitch_model dut%0d k=%0d: got %b expected %b",
                   g, k, {z[g], zr[g], zf[g]}, {mz_w[g], mr_w[g], mf_w[g]});
        end
      end
      if (k == 3) a3 = 1'b1;
    end
  endtask

  task automatic test_clean_fall;
    a2 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      total++;
      if (z[0] !== 1'(k < 6) || zf[0] !== 1'(k == 6) || zr[0] !== 1'b0) begin
        bad++;
        $display("FAIL clean_fall_dut0 k=%0d: got z=%b zf=%b zr=%b expected z=%b zf=%b zr=0",
                 k, z[0], zf[0], zr[0], 1'(k < 6), 1'(k == 6));
      end
      total++;
      if (z[1] !== 1'(k < 4) || zf[1] !== 1'(k == 4)) begin
        bad++;
        $display("FAIL clean_fall_dut1 k=%0d: got z=%b zf=%b expected z=%b zf=%b",
                 k, z[1], zf[1], 1'(k < 4), 1'(k == 4));
      end
    end
  endtask

  task automatic test_reset_mid_pending;
    a2 = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (z !== 2'b10) begin
      bad++;
      $display("FAIL mid_pend_pre: got z=%b expected 10", z);
    end
    rn = 1'b0;
    #1;
    total++;
    if ({z, zr, zf} !== 6'b0) begin
      bad++;
      $display("FAIL mid_pend_async_clear: got z=%b zr=%b zf=%b expected all 0", z, zr, zf);
    end
    #2;
    rn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      total++;
      if (z[0] !== 1'(k >= 6) || zr[0] !== 1'(k == 6)) begin
        bad++;
        $display("FAIL mid_pend_requal_dut0 k=%0d: got z=%b zr=%b expected z=%b zr=%b",
                 k, z[0], zr[0], 1'(k >= 6), 1'(k == 6));
      end
      total++;
      if (z[1] !== 1'(k >= 4)) begin
        bad++;
        $display("FAIL mid_pend_requal_dut1 k=%0d: got z=%b expected %b", k, z[1], 1'(k >= 4));
      end
    end
  endtask

  task automatic test_filt1_pulse;
    a1 = 1'b0;
    repeat (10) @(negedge clk);
    a1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) a1 = 1'b0;
      total++;
      if (z[1] !== 1'(k == 4) || zr[1] !== 1'(k == 4) || zf[1] !== 1'(k == 5)) begin
        bad++;
        $display("FAIL filt1_pulse k=%0d: got z=%b zr=%b zf=%b expected z=%b zr=%b zf=%b",
                 k, z[1], zr[1], zf[1], 1'(k == 4), 1'(k == 4), 1'(k == 5));
      end
      total++;
      if (z[0] !== 1'b0 || zr[0] !== 1'b0) begin
        bad++;
        $display("FAIL filt1_pulse_dut0_quiet k=%0d: got z=%b zr=%b expected 0 0", k, z[0], zr[0]);
      end
    end
  endtask

  task automatic test_random;
    logic [2:0] v;
    v = 3'b000;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        total++;
        if ({z[g], zr[g], zf[g]} !== {mz_w[g], mr_w[g], mf_w[g]}) begin
          bad++;
          $display("FAIL random_model dut%0d cyc=%0d: got %b expected %b",
                   g, c, {z[g], zr[g], zf[g]}, {mz_w[g], mr_w[g], mf_w[g]});
        end
`ifdef GF180MCU_AND3_DBNC_STICKY_EN
        total++;
        if (zst[g] !== ms_w[g]) begin
          bad++;
          $display("FAIL random_sticky dut%0d cyc=%0d: got %b expected %b", g, c, zst[g], ms_w[g]);
        end
`endif
      end
      if ($urandom_range(0, 5) == 0) begin
        v = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 7));
      end
      {a1, a2, a3} = v;
      clr = ($urandom_range(0, 15) == 0);
      if (c == 400) begin
        #2;
        rn = 1'b0;
        #2;
        rn = 1'b1;
      end
    end
    clr = 1'b0;
  endtask

`ifdef GF180MCU_AND3_DBNC_STICKY_EN
  task automatic test_sticky;
    {a1, a2, a3} = 3'b000;
    clr = 1'b1;
    repeat (10) @(negedge clk);
    clr = 1'b0;
    {a1, a2, a3} = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      total++;
      if (zst[0] !== 1'(k >= 6)) begin
        bad++;
        $display("FAIL sticky_set k=%0d: got %b expected %b", k, zst[0], 1'(k >= 6));
      end
    end
    a1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      total++;
      if (zst[0] !== 1'b1 || z[0] !== 1'(k < 6)) begin
        bad++;
        $display("FAIL sticky_hold k=%0d: got zst=%b z=%b expected zst=1 z=%b",
                 k, zst[0], z[0], 1'(k < 6));
      end
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++;
    if (zst[0] !== 1'b0) begin
      bad++;
      $display("FAIL sticky_clear: got %b expected 0", zst[0]);
    end
    a1 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) begin
        total++;
        if (zst[0] !== 1'b1 || zr[0] !== 1'b1) begin
          bad++;
          $display("FAIL sticky_set_wins: got zst=%b zr=%b expected 1 1", zst[0], zr[0]);
        end
      end
      clr = (k == 5);
    end
    total++;
    if (zst[0] !== 1'b1) begin
      bad++;
      $display("FAIL sticky_after_coincide: got %b expected 1", zst[0]);
    end
  endtask
`endif

  initial begin
    rn = 1'b0;
    {a1, a2, a3} = 3'b000;
    clr = 1'b0;
    test_reset();
    test_glitch();
    test_clean_fall();
    test_reset_mid_pending();
    test_filt1_pulse();
    test_random();
`ifdef GF180MCU_AND3_DBNC_STICKY_EN
    test_sticky();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
